// File: rtl/instr_fetch_sequencer_pkg.sv
// rtl/instr_fetch_sequencer_pkg.sv - shared state encoding, reset PC, field positions and opcode set
package instr_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    function automatic logic is_supported_op(input logic [5:0] op);
        case (op)
            OP_SPECIAL, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
            OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_sequencer_field_split.sv
// rtl/instr_fetch_sequencer_field_split.sv - combinational slicing of an instruction word into fields
module instr_field_split
    import instr_fetch_sequencer_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] immediate
);

    assign opcode    = instr[OPCODE_LSB +: 6];
    assign rs        = instr[RS_LSB +: 5];
    assign rt        = instr[RT_LSB +: 5];
    assign rd        = instr[RD_LSB +: 5];
    assign shamt     = instr[SHAMT_LSB +: 5];
    assign funct     = instr[FUNCT_LSB +: 6];
    assign immediate = instr[IMM_LSB +: 16];

endmodule

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - single-outstanding instruction fetch FSM with redirect; optional ILLEGAL_OP_CHECK_EN
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] immediate,
    output logic [31:0] fetch_count,
    output logic        out_illegal
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  out_instr_q, out_instr_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic [31:0]  fetch_count_q, fetch_count_d;
    logic         capture;

    // A returned word is only kept when no redirect arrives alongside it.
    assign capture = (state_q == ST_REQ) && imem_ack && !redirect_valid;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        out_instr_d   = out_instr_q;
        out_pc_d      = out_pc_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (capture) begin
                    out_instr_d = imem_rdata;
                    out_pc_d    = pc_q;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    pc_d          = pc_q + 32'd4;
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = ST_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= {RESET_PC[31:2], 2'b00};
            out_instr_q   <= 32'd0;
            out_pc_q      <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_instr_q   <= out_instr_d;
            out_pc_q      <= out_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = {pc_q[31:2], 2'b00};
    assign out_valid   = (state_q == ST_HOLD);
    assign out_pc      = out_pc_q;
    assign out_instr   = out_instr_q;
    assign fetch_count = fetch_count_q;

`ifdef ILLEGAL_OP_CHECK_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q;
        if (capture) begin
            illegal_d = !is_supported_op(imem_rdata[OPCODE_LSB +: 6]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign out_illegal = illegal_q && out_valid;
`else
    assign out_illegal = 1'b0;
`endif

    instr_field_split u_field_split (
        .instr     (out_instr_q),
        .opcode    (opcode),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .shamt     (shamt),
        .funct     (funct),
        .immediate (immediate)
    );

endmodule
